// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Bundle of the store buffer's bus signals. It carries the ROB
//                commit port, the DataCache write port and the load-forwarding
//                probe port.
//                  slave  : the store buffer itself
//                  master : the environment (ROB / DataCache / LSU)
//                Ports:
//                  in_write/in_mask/in_addr/in_data  committed store in
//                  in_ready                          buffer can accept
//                  mem_req/mem_mask/mem_addr/mem_data DataCache write request
//                  mem_ack                           DataCache write complete
//                  ld_check/ld_addr                  forwarding probe
//                  ld_match/ld_full/ld_data          forwarding result
//                  empty                             nothing buffered/pending
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_write;
    logic [3:0]            in_mask;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  mem_req;
    logic [3:0]            mem_mask;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ack;

    logic                  ld_check;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_match;
    logic                  ld_full;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  empty;

    modport slave (
        input  in_write, in_mask, in_addr, in_data,
        output in_ready,
        output mem_req, mem_mask, mem_addr, mem_data,
        input  mem_ack,
        input  ld_check, ld_addr,
        output ld_match, ld_full, ld_data,
        output empty
    );

    modport master (
        output in_write, in_mask, in_addr, in_data,
        input  in_ready,
        input  mem_req, mem_mask, mem_addr, mem_data,
        output mem_ack,
        output ld_check, ld_addr,
        input  ld_match, ld_full, ld_data,
        input  empty
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Circular FIFO of committed stores. It drains them one at a
//                time to the DataCache through a two-state request FSM and
//                forwards the youngest matching pending store to load probes.
//                Ports:
//                  clk  - clock, all state updates on rising edge
//                  rst  - synchronous active-high reset
//                  bus  - store_buffer_if.slave (commit, DataCache, probe)
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire            clk,
    input  wire            rst,
    store_buffer_if.slave  bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Entry storage; contents are meaningless outside [head, head+count).
    logic [3:0]            r_mask [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    state_t                r_state;

    logic                  r_mem_req;
    logic [3:0]            r_mem_mask;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;

    logic                  w_ld_match;
    logic                  w_ld_full;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_ld_unused;

    // Ready depends on the registered count alone so the ROB never sees a
    // combinational loop through its own write strobe.
    assign w_in_ready = (r_count != c_DEPTH);
    assign w_push     = bus.in_write && w_in_ready;
    assign w_pop      = (r_state == S_REQ) && bus.mem_ack;

    // ------------------------------------------------------------------------
    // Entry storage (no reset: contents are don't-care until pushed)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mask[r_tail] <= bus.in_mask;
            r_addr[r_tail] <= bus.in_addr;
            r_data[r_tail] <= bus.in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and drain FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_mask <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end

            // A push and a pop in the same cycle cancel out in the count.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    // Uses the count before this edge's push, so a freshly
                    // committed store is requested one cycle after it lands.
                    if (r_count != '0) begin
                        r_mem_mask <= r_mask[r_head];
                        r_mem_addr <= r_addr[r_head];
                        r_mem_data <= r_data[r_head];
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The head entry stays in the FIFO (and visible to loads)
                    // until the DataCache acknowledges it.
                    if (bus.mem_ack) begin
                        r_head    <= r_head + 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Load forwarding: scan oldest to youngest so the youngest match wins.
    // ------------------------------------------------------------------------
    always_comb begin : forward
        logic [c_PTR_W-1:0] v_idx;
        w_ld_match = 1'b0;
        w_ld_full  = 1'b0;
        w_ld_data  = '0;
        v_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + c_PTR_W'(i);
            if (bus.ld_check && (c_CNT_W'(i) < r_count) &&
                (r_addr[v_idx][ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2])) begin
                w_ld_match = 1'b1;
                w_ld_full  = (r_mask[v_idx] == 4'b1111);
                w_ld_data  = r_data[v_idx];
            end
        end
    end

    // Byte offset of the probe is irrelevant: matching is per word.
    assign w_ld_unused = ^bus.ld_addr[1:0];

    assign bus.in_ready = w_in_ready;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_mask = r_mem_mask;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.ld_match = w_ld_match;
    assign bus.ld_full  = w_ld_full;
    assign bus.ld_data  = w_ld_data;
    assign bus.empty    = (r_count == '0) && (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A queue-based model of
//                the buffer is compared against the DUT every cycle, and
//                directed scenarios pin specific literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    store_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: an ordered list of pending stores plus a "request outstanding"
    // flag. The oldest store is the one on the DataCache bus while requested.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [3:0]    mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    st_t q[$];
    bit  m_req   = 1'b0;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit  go;
        bit  pop;
        bit  push;
        st_t e;
        if (rst) begin
            q.delete();
            m_req   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            go   = !m_req && (q.size() != 0);
            pop  = m_req && bus.mem_ack;
            push = bus.in_write && (q.size() < DEPTH);
            if (pop) begin
                void'(q.pop_front());
                m_req = 1'b0;
            end else if (go) begin
                m_req = 1'b1;
            end
            if (push) begin
                e.mask = bus.in_mask;
                e.addr = bus.in_addr;
                e.data = bus.in_data;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit            f_match;
        bit            f_full;
        logic [DW-1:0] f_data;
        if (m_valid) begin
            f_match = 1'b0;
            f_full  = 1'b0;
            f_data  = '0;
            if (bus.ld_check) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].addr[AW-1:2] == bus.ld_addr[AW-1:2]) begin
                        f_match = 1'b1;
                        f_full  = (q[i].mask == 4'b1111);
                        f_data  = q[i].data;
                        break;
                    end
                end
            end
            check("m_in_ready", bus.in_ready, q.size() < DEPTH);
            check("m_mem_req",  bus.mem_req,  m_req);
            check("m_empty",    bus.empty,    (q.size() == 0) && !m_req);
            check("m_ld_match", bus.ld_match, f_match);
            check("m_ld_full",  bus.ld_full,  f_full);
            check("m_ld_data",  bus.ld_data,  f_data);
            if (m_req) begin
                check("m_mem_mask", bus.mem_mask, q[0].mask);
                check("m_mem_addr", bus.mem_addr, q[0].addr);
                check("m_mem_data", bus.mem_data, q[0].data);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge+1 or negedge phase)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.in_write = 1'b1;
        bus.in_mask  = m;
        bus.in_addr  = a;
        bus.in_data  = d;
        tick();
        bus.in_write = 1'b0;
    endtask

    // Waits (bounded) for a request, pins its address, then acks it once.
    task automatic ack_one(input logic [AW-1:0] exp_addr);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_req",  bus.mem_req,  1'b1);
        check("drain_addr", bus.mem_addr, exp_addr);
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_write = 1'b0;
        bus.in_mask  = '0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.mem_ack  = 1'b0;
        bus.ld_check = 1'b1;
        bus.ld_addr  = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_req",  bus.mem_req,  1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_empty",    bus.empty,    1'b1);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_data", bus.mem_data, 32'h0);
        check("rst_mem_mask", bus.mem_mask, 4'h0);
        check("rst_ld_match", bus.ld_match, 1'b0);

        // Single store, ack raised two cycles after mem_req
        push(4'b1111, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("single_req_c0", bus.mem_req, 1'b0);
        check("single_empty0", bus.empty,   1'b0);
        tick();
        @(negedge clk);
        check("single_req_c1", bus.mem_req,  1'b1);
        check("single_addr",   bus.mem_addr, 32'h100);
        check("single_data",   bus.mem_data, 32'hDEADBEEF);
        check("single_mask",   bus.mem_mask, 4'hF);
        tick();
        @(negedge clk);
        check("single_req_c2", bus.mem_req, 1'b1);
        tick();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("single_req_c3", bus.mem_req, 1'b1);
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("single_req_c4", bus.mem_req, 1'b0);
        check("single_empty",  bus.empty,   1'b1);

        // Fill to capacity, drop a fifth push, drain in order
        bus.ld_addr = 32'h8;
        for (int i = 0; i < 4; i++) push(4'b1111, 32'(i * 4), 32'h1000 + 32'(i));
        @(negedge clk);
        check("fill_ready", bus.in_ready, 1'b0);
        push(4'b1111, 32'h10, 32'h1004);
        @(negedge clk);
        check("fill_ready2", bus.in_ready, 1'b0);
        ack_one(32'h0);
        ack_one(32'h4);
        ack_one(32'h8);
        ack_one(32'hC);
        @(negedge clk);
        check("fill_empty", bus.empty, 1'b1);
        tick();

        // Simultaneous push and ack while full: push is dropped
        for (int i = 0; i < 4; i++) push(4'b0001, 32'h20 + 32'(i * 4), 32'h2000 + 32'(i));
        @(negedge clk);
        check("full_ack_req", bus.mem_req, 1'b1);
        bus.in_write = 1'b1;
        bus.in_addr  = 32'h40;
        bus.in_data  = 32'h4040;
        bus.mem_ack  = 1'b1;
        tick();
        bus.in_write = 1'b0;
        bus.mem_ack  = 1'b0;
        ack_one(32'h24);
        ack_one(32'h28);
        ack_one(32'h2C);
        @(negedge clk);
        check("full_ack_empty", bus.empty, 1'b1);
        tick();

        // Simultaneous push and ack at count 2: count holds, order kept
        push(4'b1111, 32'h50, 32'h5050);
        push(4'b1111, 32'h54, 32'h5454);
        @(negedge clk);
        check("two_req_addr", bus.mem_addr, 32'h50);
        bus.in_write = 1'b1;
        bus.in_mask  = 4'b1111;
        bus.in_addr  = 32'h58;
        bus.in_data  = 32'h5858;
        bus.mem_ack  = 1'b1;
        tick();
        bus.in_write = 1'b0;
        bus.mem_ack  = 1'b0;
        @(negedge clk);
        check("two_ready", bus.in_ready, 1'b1);
        ack_one(32'h54);
        ack_one(32'h58);
        @(negedge clk);
        check("two_empty", bus.empty, 1'b1);
        tick();

        // Forwarding: youngest of two stores to the same word wins
        push(4'b0001, 32'h200, 32'hAA);
        push(4'b1111, 32'h200, 32'h11223344);
        bus.ld_addr = 32'h202;
        @(negedge clk);
        check("fwd_match", bus.ld_match, 1'b1);
        check("fwd_full",  bus.ld_full,  1'b1);
        check("fwd_data",  bus.ld_data,  32'h11223344);
        bus.ld_addr = 32'h204;
        #1;
        check("fwd_miss_match", bus.ld_match, 1'b0);
        check("fwd_miss_full",  bus.ld_full,  1'b0);
        check("fwd_miss_data",  bus.ld_data,  32'h0);
        bus.ld_addr  = 32'h200;
        bus.ld_check = 1'b0;
        #1;
        check("fwd_nochk_match", bus.ld_match, 1'b0);
        bus.ld_check = 1'b1;
        ack_one(32'h200);
        ack_one(32'h200);

        // Partial store stays visible until its ack edge
        push(4'b0011, 32'h300, 32'hBEEF);
        bus.ld_addr = 32'h300;
        @(negedge clk);
        check("part_match", bus.ld_match, 1'b1);
        check("part_full",  bus.ld_full,  1'b0);
        check("part_data",  bus.ld_data,  32'hBEEF);
        ack_one(32'h300);
        @(negedge clk);
        check("part_gone", bus.ld_match, 1'b0);
        tick();

        // Reset in the middle of a request with three entries buffered;
        // a push in the reset cycle must be ignored
        push(4'b1111, 32'h400, 32'h1);
        push(4'b1111, 32'h404, 32'h2);
        push(4'b1111, 32'h408, 32'h3);
        bus.ld_addr = 32'h400;
        @(negedge clk);
        check("mid_req", bus.mem_req, 1'b1);
        rst          = 1'b1;
        bus.in_write = 1'b1;
        bus.in_addr  = 32'h500;
        tick();
        rst          = 1'b0;
        bus.in_write = 1'b0;
        @(negedge clk);
        check("mid_rst_req",   bus.mem_req,  1'b0);
        check("mid_rst_ready", bus.in_ready, 1'b1);
        check("mid_rst_empty", bus.empty,    1'b1);
        check("mid_rst_match", bus.ld_match, 1'b0);

        // Recovery after reset
        push(4'b1111, 32'h600, 32'h6060);
        ack_one(32'h600);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered committed stores (power of two, ≥2).
REQ-002 SHALL have `clk  in  1  clock; all state updates on rising edge`.
REQ-003 SHALL have `rst  in  1  reset`; rst is synchronous, active-high; clock is clk.
REQ-004 SHALL have `in_write  in  1  ROB commits a store this cycle`.
REQ-005 SHALL have `in_mask  in  4  byte-enable mask, lane-aligned`.
REQ-006 SHALL have `in_addr  in  Addr_Width  word-aligned store address`.
REQ-007 SHALL have `in_data  in  Data_Width  lane-shifted store data`.
REQ-008 SHALL have `in_ready  out  1  buffer can accept; drives the ROB's dcache_write_valid`.
REQ-009 SHALL have `mem_req  out  1  write request to DataCache`.
REQ-010 SHALL have `mem_mask / mem_addr / mem_data  out  4 / Addr_Width / Data_Width  request payload`.
REQ-011 SHALL have `mem_ack  in  1  DataCache completed the current write`.
REQ-012 SHALL have `ld_check  in  1  load/store unit probes for a pending store`.
REQ-013 SHALL have `ld_addr  in  Addr_Width  load address`.
REQ-014 SHALL have `ld_match / ld_full  out  1 / 1  youngest matching store exists / has mask 4'b1111`.
REQ-015 SHALL have `ld_data  out  Data_Width  data of youngest matching store`.
REQ-016 SHALL have `empty  out  1  no buffered stores and no request outstanding`.

Function
REQ-017 SHALL hold stores in a circular FIFO: head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-018 SHALL drive in_ready = (count != DEPTH) combinationally from registered count only; it has no path from in_write.
REQ-019 SHALL push {mask, addr, data} at tail and increment tail when in_write && in_ready.
REQ-020 SHALL silently drop in_write while full, with no state change.
REQ-021 SHALL drain through a 2-state FSM, IDLE and REQ, held in registers.
REQ-022 IDLE SHALL go to REQ when count != 0, latching the head entry into mem_mask/addr/data and setting mem_req=1 on the next edge.
REQ-023 REQ SHALL hold mem_req and the payload stable until mem_ack, then pop head, decrement count, clear mem_req and go to IDLE.
REQ-024 Drain latency SHALL be: first mem_req 1 cycle after the push edge; one idle bubble after every ack.
REQ-025 SHALL ignore mem_ack in IDLE.
REQ-026 SHALL keep count unchanged on a simultaneous push and pop; both pointers advance.
REQ-027 SHALL keep an entry visible to forwarding until the edge that pops it; an entry pushed in the same cycle is not visible.
REQ-028 Forwarding SHALL be combinational: compare ld_addr[Addr_Width-1:2] against all valid entries; youngest (closest to tail) match wins.
REQ-029 SHALL force ld_match, ld_full and ld_data to 0 when ld_check=0 or there is no match.
REQ-030 SHALL drive empty = (count==0 && state==IDLE).

Reset
REQ-031 On rst SHALL clear head, tail, count, state=IDLE, mem_req=0, mem_mask=0, mem_addr=0, mem_data=0; rst has priority over in_write and mem_ack in the same cycle.
REQ-032 Reset during REQ SHALL abandon the outstanding request (the DataCache is reset together).
REQ-033 Entry contents are don't-care after reset; ld_match SHALL be 0 after reset.

Verification
REQ-034 Single store: push {4'b1111, 0x100, 0xDEADBEEF}, ack 2 cycles after mem_req -> mem_req is high 1 cycle after the push and holds for 3 cycles; then empty=1.
REQ-035 Fill: 4 pushes with no ack -> in_ready=0; a 5th push is dropped; then 4 acks -> stores drain in order with addresses 0x0, 0x4, 0x8, 0xC.
REQ-036 Simultaneous push and ack at count=4 -> push dropped because in_ready=0; at count=2 -> count stays 2; after 8 total stores the pointers wrap and order is preserved.
REQ-037 Forwarding: push {0001, 0x200, 0xAA} then {1111, 0x200, 0x11223344}; probe 0x202 -> ld_match=1, ld_full=1, ld_data=0x11223344; probe 0x204 -> all 0.
REQ-038 Partial: the single store {0011, 0x300, 0xBEEF} is buffered; probe 0x300 -> ld_match=1, ld_full=0; after its ack edge, same probe -> ld_match=0.
REQ-039 Reset mid-REQ with 3 entries -> next cycle mem_req=0, in_ready=1, empty=1.
